// File: rtl/ft_lockstep_monitor.sv
`default_nettype none
// ============================================================================
// ft_lockstep_monitor: pairs, compares and merges dual-core data requests.
// Revision: 1.0
// ============================================================================

module ft_lockstep_monitor #(
  parameter int TIMEOUT        = 8,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        c0_req_i,
  input  logic        c0_we_i,
  input  logic [31:0] c0_addr_i,
  input  logic [31:0] c0_wdata_i,
  input  logic [3:0]  c0_be_i,
  input  logic        c1_req_i,
  input  logic        c1_we_i,
  input  logic [31:0] c1_addr_i,
  input  logic [31:0] c1_wdata_i,
  input  logic [3:0]  c1_be_i,
  output logic        c_gnt_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  output logic        error_o,
  output logic        halt_o,
  output logic        recover_o,
  output logic [15:0] err_count_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_ISSUE   = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  logic        v0_q, v0_d, v1_q, v1_d;
  logic        s0_we_q, s0_we_d, s1_we_q, s1_we_d;
  logic [31:0] s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d;
  logic [31:0] s0_wdata_q, s0_wdata_d, s1_wdata_q, s1_wdata_d;
  logic [3:0]  s0_be_q, s0_be_d, s1_be_q, s1_be_d;

  logic        error_q, error_d;
  logic [15:0] cnt_q, cnt_d;

  logic        lat0, lat1, clr, mismatch;

  // Write data only participates in the comparison for writes.
  assign mismatch = (s0_we_q != s1_we_q) || (s0_addr_q != s1_addr_q) ||
                    (s0_be_q != s1_be_q) || (s0_we_q && (s0_wdata_q != s1_wdata_q));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rcnt_d     = rcnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    s0_we_d    = s0_we_q;
    s0_addr_d  = s0_addr_q;
    s0_wdata_d = s0_wdata_q;
    s0_be_d    = s0_be_q;
    s1_we_d    = s1_we_q;
    s1_addr_d  = s1_addr_q;
    s1_wdata_d = s1_wdata_q;
    s1_be_d    = s1_be_q;
    lat0       = 1'b0;
    lat1       = 1'b0;
    clr        = 1'b0;

    case (state_q)
      S_IDLE: begin
        lat0    = c0_req_i;
        lat1    = c1_req_i;
        timer_d = '0;
        if (c0_req_i && c1_req_i)
          state_d = S_CHECK;
        else if (c0_req_i || c1_req_i)
          state_d = S_COLLECT;
      end
      S_COLLECT: begin
        // An already-latched core is ignored until the pair completes.
        lat0    = c0_req_i && !v0_q;
        lat1    = c1_req_i && !v1_q;
        timer_d = timer_q + TW'(1);
        if (lat0 || lat1)
          state_d = S_CHECK;
        else if (timer_q == TW'(TIMEOUT - 1))
          state_d = S_RECOVER;
      end
      S_CHECK: begin
        state_d = mismatch ? S_RECOVER : S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_gnt_i) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RECOVER: begin
        clr = 1'b1;
        if (rcnt_q == RW'(RECOVER_CYCLES - 1)) begin
          rcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (lat0) begin
      v0_d       = 1'b1;
      s0_we_d    = c0_we_i;
      s0_addr_d  = c0_addr_i;
      s0_wdata_d = c0_wdata_i;
      s0_be_d    = c0_be_i;
    end
    if (lat1) begin
      v1_d       = 1'b1;
      s1_we_d    = c1_we_i;
      s1_addr_d  = c1_addr_i;
      s1_wdata_d = c1_wdata_i;
      s1_be_d    = c1_be_i;
    end
    if (clr) begin
      v0_d       = 1'b0;
      v1_d       = 1'b0;
      s0_we_d    = 1'b0;
      s0_addr_d  = '0;
      s0_wdata_d = '0;
      s0_be_d    = '0;
      s1_we_d    = 1'b0;
      s1_addr_d  = '0;
      s1_wdata_d = '0;
      s1_be_d    = '0;
      timer_d    = '0;
    end

    error_d = (state_d == S_RECOVER) && (state_q != S_RECOVER);
    cnt_d   = (error_d && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      rcnt_q     <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      s0_we_q    <= 1'b0;
      s0_addr_q  <= '0;
      s0_wdata_q <= '0;
      s0_be_q    <= '0;
      s1_we_q    <= 1'b0;
      s1_addr_q  <= '0;
      s1_wdata_q <= '0;
      s1_be_q    <= '0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rcnt_q     <= rcnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      s0_we_q    <= s0_we_d;
      s0_addr_q  <= s0_addr_d;
      s0_wdata_q <= s0_wdata_d;
      s0_be_q    <= s0_be_d;
      s1_we_q    <= s1_we_d;
      s1_addr_q  <= s1_addr_d;
      s1_wdata_q <= s1_wdata_d;
      s1_be_q    <= s1_be_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  logic issue;
  assign issue       = (state_q == S_ISSUE);
  assign mem_req_o   = issue;
  assign mem_we_o    = issue && s0_we_q;
  assign mem_addr_o  = issue ? s0_addr_q  : 32'd0;
  assign mem_wdata_o = issue ? s0_wdata_q : 32'd0;
  assign mem_be_o    = issue ? s0_be_q    : 4'd0;
  // A pair aborted by reset must never see a grant.
  assign c_gnt_o     = issue && mem_gnt_i && !rst_i;
  assign halt_o      = (state_q == S_RECOVER);
  assign recover_o   = (state_q == S_RECOVER) && (rcnt_q == RW'(RECOVER_CYCLES - 1));
  assign error_o     = error_q;
  assign err_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ft_lockstep_monitor.sv
`default_nettype none
// ============================================================================
// tb_ft_lockstep_monitor: directed self-checking bench for ft_lockstep_monitor.
// Revision: 1.0
// ============================================================================

module tb_ft_lockstep_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req_i, c0_we_i, c1_req_i, c1_we_i;
  logic [31:0] c0_addr_i, c0_wdata_i, c1_addr_i, c1_wdata_i;
  logic [3:0]  c0_be_i, c1_be_i;
  logic        c_gnt_o, mem_req_o, mem_we_o, mem_gnt_i;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        error_o, halt_o, recover_o;
  logic [15:0] err_count_o;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  int nreq, firstreq, ngnt, firstgnt, badgnt, unstable;
  int nerr, firsterr, nhalt, firsthalt, nrec, reccyc;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [3:0]  req_be;

  always #5 clk = ~clk;

  ft_lockstep_monitor #(.TIMEOUT(8), .RECOVER_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .c0_req_i(c0_req_i), .c0_we_i(c0_we_i), .c0_addr_i(c0_addr_i),
    .c0_wdata_i(c0_wdata_i), .c0_be_i(c0_be_i),
    .c1_req_i(c1_req_i), .c1_we_i(c1_we_i), .c1_addr_i(c1_addr_i),
    .c1_wdata_i(c1_wdata_i), .c1_be_i(c1_be_i),
    .c_gnt_o(c_gnt_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .error_o(error_o), .halt_o(halt_o),
    .recover_o(recover_o), .err_count_o(err_count_o)
  );

  task automatic set_cores(input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [3:0] b0, input logic we1, input logic [31:0] a1,
                           input logic [31:0] d1, input logic [3:0] b1);
    c0_we_i = we0; c0_addr_i = a0; c0_wdata_i = d0; c0_be_i = b0;
    c1_we_i = we1; c1_addr_i = a1; c1_wdata_i = d1; c1_be_i = b1;
  endtask

  // Cores raise requests at given cycles and hold them until c_gnt_o or
  // recover_o; per-cycle observations are gathered into the stat variables.
  task automatic run_pair(input int ncyc, input int c0_at, input int c1_at,
                          input int gnt_at, input bit scramble);
    logic [31:0] base_addr;
    bit done;
    base_addr = c0_addr_i;
    done = 0;
    nreq = 0; firstreq = -1; ngnt = 0; firstgnt = -1; badgnt = 0; unstable = 0;
    nerr = 0; firsterr = -1; nhalt = 0; firsthalt = -1; nrec = 0; reccyc = -1;
    req_addr = '0; req_wdata = '0; req_we = 1'b0; req_be = '0;
    for (int cy = 0; cy < ncyc; cy++) begin
      c0_req_i  = !done && (c0_at >= 0) && (cy >= c0_at);
      c1_req_i  = !done && (c1_at >= 0) && (cy >= c1_at);
      mem_gnt_i = (gnt_at >= 0) && (cy >= gnt_at);
      if (scramble && cy > c0_at) c0_addr_i = base_addr ^ 32'h100;
      @(negedge clk);
      if (mem_req_o) begin
        nreq++;
        if (firstreq < 0) begin
          firstreq = cy; req_addr = mem_addr_o; req_wdata = mem_wdata_o;
          req_we = mem_we_o; req_be = mem_be_o;
        end else if (mem_addr_o !== req_addr || mem_wdata_o !== req_wdata ||
                     mem_we_o !== req_we || mem_be_o !== req_be) begin
          unstable++;
        end
      end
      if (c_gnt_o) begin
        ngnt++;
        if (firstgnt < 0) firstgnt = cy;
        if (!(mem_req_o && mem_gnt_i)) badgnt++;
      end
      if (error_o) begin nerr++; if (firsterr < 0) firsterr = cy; end
      if (halt_o) begin nhalt++; if (firsthalt < 0) firsthalt = cy; end
      if (recover_o) begin nrec++; reccyc = cy; end
      if (c_gnt_o || recover_o) done = 1;
      @(posedge clk); #1;
    end
    c0_req_i = 1'b0; c1_req_i = 1'b0; mem_gnt_i = 1'b0; c0_addr_i = base_addr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c0_req_i = 1'b1; c1_req_i = 1'b1; mem_gnt_i = 1'b1;
    set_cores(1'b1, 32'hDEAD, 32'h1, 4'hF, 1'b0, 32'hBEEF, 32'h2, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_total++; if (mem_req_o !== 1'b0) $display("FAIL rst_mem_req got %b want 0", mem_req_o); else n_pass++;
    n_total++; if (c_gnt_o !== 1'b0) $display("FAIL rst_c_gnt got %b want 0", c_gnt_o); else n_pass++;
    n_total++; if ({error_o, halt_o, recover_o} !== 3'b000)
      $display("FAIL rst_err_halt_rec got %b want 000", {error_o, halt_o, recover_o}); else n_pass++;
    n_total++; if (err_count_o !== 16'd0) $display("FAIL rst_err_count got %0d want 0", err_count_o); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; c0_req_i = 1'b0; c1_req_i = 1'b0; mem_gnt_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_match_write();
    set_cores(1'b1, 32'h4, 32'h1, 4'hF, 1'b1, 32'h4, 32'h1, 4'hF);
    run_pair(8, 0, 0, 0, 0);
    n_total++; if (firstreq !== 2) $display("FAIL wr_req_cycle got %0d want 2", firstreq); else n_pass++;
    n_total++; if (nreq !== 1) $display("FAIL wr_req_count got %0d want 1", nreq); else n_pass++;
    n_total++; if (req_addr !== 32'h4) $display("FAIL wr_addr got %h want 4", req_addr); else n_pass++;
    n_total++; if (req_wdata !== 32'h1) $display("FAIL wr_wdata got %h want 1", req_wdata); else n_pass++;
    n_total++; if ({req_we, req_be} !== 5'b1_1111) $display("FAIL wr_we_be got %b want 11111", {req_we, req_be}); else n_pass++;
    n_total++; if (ngnt !== 1 || firstgnt !== 2) $display("FAIL wr_gnt got n=%0d at %0d want n=1 at 2", ngnt, firstgnt); else n_pass++;
    n_total++; if (nerr !== 0) $display("FAIL wr_error got %0d want 0", nerr); else n_pass++;
    n_total++; if (badgnt !== 0) $display("FAIL wr_orphan_gnt got %0d want 0", badgnt); else n_pass++;
  endtask

  task automatic test_skewed_read();
    set_cores(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h8, 32'h0, 4'hF);
    run_pair(12, 0, 3, 0, 1);
    n_total++; if (firstreq !== 5) $display("FAIL skew_req_cycle got %0d want 5", firstreq); else n_pass++;
    n_total++; if (nreq !== 1 || req_addr !== 32'h8 || req_we !== 1'b0)
      $display("FAIL skew_read got n=%0d addr=%h we=%b want n=1 addr=8 we=0", nreq, req_addr, req_we); else n_pass++;
    n_total++; if (nerr !== 0) $display("FAIL skew_error got %0d want 0", nerr); else n_pass++;
    n_total++; if (err_count_o !== 16'(exp_cnt)) $display("FAIL skew_err_count got %0d want %0d", err_count_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_wdata_mismatch();
    set_cores(1'b1, 32'h4, 32'h1, 4'hF, 1'b1, 32'h4, 32'h3, 4'hF);
    run_pair(10, 0, 0, 0, 0);
    exp_cnt++;
    n_total++; if (nreq !== 0) $display("FAIL mm_mem_req got %0d want 0", nreq); else n_pass++;
    n_total++; if (nerr !== 1 || firsterr !== 2) $display("FAIL mm_error got n=%0d at %0d want n=1 at 2", nerr, firsterr); else n_pass++;
    n_total++; if (nhalt !== 4 || firsthalt !== 2) $display("FAIL mm_halt got n=%0d at %0d want n=4 at 2", nhalt, firsthalt); else n_pass++;
    n_total++; if (nrec !== 1 || reccyc !== 5) $display("FAIL mm_recover got n=%0d at %0d want n=1 at 5", nrec, reccyc); else n_pass++;
    n_total++; if (ngnt !== 0) $display("FAIL mm_gnt got %0d want 0", ngnt); else n_pass++;
    n_total++; if (err_count_o !== 16'(exp_cnt)) $display("FAIL mm_err_count got %0d want %0d", err_count_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    set_cores(1'b0, 32'h50, 32'h0, 4'hF, 1'b0, 32'h50, 32'h0, 4'hF);
    run_pair(16, 0, -1, 0, 0);
    exp_cnt++;
    n_total++; if (nerr !== 1 || firsterr !== 9) $display("FAIL to_error got n=%0d at %0d want n=1 at 9", nerr, firsterr); else n_pass++;
    n_total++; if (nhalt !== 4 || firsthalt !== 9) $display("FAIL to_halt got n=%0d at %0d want n=4 at 9", nhalt, firsthalt); else n_pass++;
    n_total++; if (reccyc !== 12) $display("FAIL to_recover got %0d want 12", reccyc); else n_pass++;
    n_total++; if (nreq !== 0) $display("FAIL to_mem_req got %0d want 0", nreq); else n_pass++;
    n_total++; if (err_count_o !== 16'(exp_cnt)) $display("FAIL to_err_count got %0d want %0d", err_count_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_late_arrival();
    set_cores(1'b0, 32'hC, 32'h0, 4'hF, 1'b0, 32'hC, 32'h0, 4'hF);
    run_pair(14, 0, 8, 0, 0);
    n_total++; if (firstreq !== 10 || req_addr !== 32'hC)
      $display("FAIL late_req got cyc=%0d addr=%h want cyc=10 addr=c", firstreq, req_addr); else n_pass++;
    n_total++; if (nerr !== 0 || nhalt !== 0) $display("FAIL late_error got err=%0d halt=%0d want 0/0", nerr, nhalt); else n_pass++;
  endtask

  task automatic test_read_wdata_ignored();
    set_cores(1'b0, 32'h10, 32'h11, 4'hF, 1'b0, 32'h10, 32'h22, 4'hF);
    run_pair(8, 0, 0, 0, 0);
    n_total++; if (firstreq !== 2 || req_we !== 1'b0 || req_addr !== 32'h10)
      $display("FAIL rd_wd_req got cyc=%0d we=%b addr=%h want cyc=2 we=0 addr=10", firstreq, req_we, req_addr); else n_pass++;
    n_total++; if (nerr !== 0) $display("FAIL rd_wd_error got %0d want 0", nerr); else n_pass++;
  endtask

  task automatic test_be_mismatch();
    set_cores(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h20, 32'h0, 4'h3);
    run_pair(10, 0, 0, 0, 0);
    exp_cnt++;
    n_total++; if (nreq !== 0 || nerr !== 1) $display("FAIL be_mm got req=%0d err=%0d want 0/1", nreq, nerr); else n_pass++;
    n_total++; if (err_count_o !== 16'(exp_cnt)) $display("FAIL be_err_count got %0d want %0d", err_count_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_gnt_delay();
    set_cores(1'b1, 32'h30, 32'hAB, 4'h5, 1'b1, 32'h30, 32'hAB, 4'h5);
    run_pair(10, 0, 0, 5, 0);
    n_total++; if (firstreq !== 2 || nreq !== 4) $display("FAIL gd_req got cyc=%0d n=%0d want cyc=2 n=4", firstreq, nreq); else n_pass++;
    n_total++; if (unstable !== 0) $display("FAIL gd_stable got %0d want 0", unstable); else n_pass++;
    n_total++; if (ngnt !== 1 || firstgnt !== 5) $display("FAIL gd_gnt got n=%0d at %0d want n=1 at 5", ngnt, firstgnt); else n_pass++;
    n_total++; if (req_wdata !== 32'hAB || req_be !== 4'h5)
      $display("FAIL gd_fields got wd=%h be=%h want wd=ab be=5", req_wdata, req_be); else n_pass++;
  endtask

  task automatic test_reset_in_issue();
    set_cores(1'b1, 32'h40, 32'h7, 4'hF, 1'b1, 32'h40, 32'h7, 4'hF);
    run_pair(4, 0, 0, -1, 0);
    n_total++; if (nreq !== 2 || ngnt !== 0) $display("FAIL ri_wait got req=%0d gnt=%0d want 2/0", nreq, ngnt); else n_pass++;
    rst = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    n_total++; if (c_gnt_o !== 1'b0) $display("FAIL ri_gnt_in_reset got %b want 0", c_gnt_o); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; mem_gnt_i = 1'b0; exp_cnt = 0;
    @(negedge clk);
    n_total++; if (mem_req_o !== 1'b0) $display("FAIL ri_mem_req got %b want 0", mem_req_o); else n_pass++;
    n_total++; if (err_count_o !== 16'd0) $display("FAIL ri_err_count got %0d want 0", err_count_o); else n_pass++;
    @(posedge clk); #1;
    set_cores(1'b0, 32'h44, 32'h0, 4'hF, 1'b0, 32'h44, 32'h0, 4'hF);
    run_pair(6, 0, 0, 0, 0);
    n_total++; if (firstreq !== 2 || req_addr !== 32'h44 || ngnt !== 1)
      $display("FAIL ri_next_pair got cyc=%0d addr=%h gnt=%0d want 2/44/1", firstreq, req_addr, ngnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_cores(1'b1, 32'h60, 32'h5, 4'hF, 1'b1, 32'h60, 32'h5, 4'hF);
    run_pair(4, 0, 0, 0, 0);
    n_total++; if (firstreq !== 2 || ngnt !== 1) $display("FAIL b2b_first got cyc=%0d gnt=%0d want 2/1", firstreq, ngnt); else n_pass++;
    set_cores(1'b0, 32'h64, 32'h0, 4'h3, 1'b0, 32'h64, 32'h0, 4'h3);
    run_pair(4, 0, 0, 0, 0);
    n_total++; if (firstreq !== 2 || req_addr !== 32'h64 || req_be !== 4'h3)
      $display("FAIL b2b_second got cyc=%0d addr=%h be=%h want 2/64/3", firstreq, req_addr, req_be); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; mem_gnt_i = 1'b0; c0_req_i = 1'b0; c1_req_i = 1'b0;
    set_cores(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    test_reset();
    test_match_write();
    test_skewed_read();
    test_wdata_mismatch();
    test_timeout();
    test_late_arrival();
    test_read_wdata_ignored();
    test_be_mismatch();
    test_gnt_delay();
    test_reset_in_issue();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ft_lockstep_monitor.md
FT_LOCKSTEP_MONITOR -- requirements
Module: ft_lockstep_monitor

Interface
REQ-001 Parameter TIMEOUT, default 8: max cycles between the first and second core request of a pair.
REQ-002 Parameter RECOVER_CYCLES, default 4: length of the recovery window in cycles, >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 c0_req_i / c1_req_i  input  1  data request from core_0 / core_1; held high until c_gnt_o.
REQ-006 c0_we_i / c1_we_i  input  1  write enable per core.
REQ-007 c0_addr_i / c1_addr_i  input  32  byte address per core.
REQ-008 c0_wdata_i / c1_wdata_i  input  32  write data per core.
REQ-009 c0_be_i / c1_be_i  input  4  byte enables per core.
REQ-010 c_gnt_o  output  1  one-cycle grant returned to both cores.
REQ-011 mem_req_o, mem_we_o, mem_addr_o[32], mem_wdata_o[32], mem_be_o[4]  output  merged request to data memory.
REQ-012 mem_gnt_i  input  1  memory accepts request in the cycle it is high with mem_req_o.
REQ-013 error_o  output  1  one-cycle pulse per detected lockstep divergence.
REQ-014 halt_o  output  1  stalls both cores while high.
REQ-015 recover_o  output  1  one-cycle rollback strobe to cores.
REQ-016 err_count_o  output  16  saturating count of detected divergences.

Function
REQ-017 FSM states IDLE, COLLECT, CHECK, ISSUE, RECOVER; reset state IDLE.
REQ-018 IDLE: any cN_req_i high latches that core's fields into slot N, sets valid_N; both high in same cycle -> both latched, next state CHECK; one high -> COLLECT, timer cleared to 0.
REQ-019 COLLECT: timer increments each cycle; missing core's request latches on arrival -> CHECK; timer == TIMEOUT-1 without arrival -> RECOVER.
REQ-020 Slot fields latch once per pair; later changes on an already-latched core's inputs are ignored until pair completion.
REQ-021 CHECK (exactly one cycle): mismatch = we, addr or be differ, or (we==1 and wdata differ); match -> ISSUE, mismatch -> RECOVER.
REQ-022 ISSUE: mem_req_o=1 with slot-0 fields, held stable until mem_gnt_i; on grant cycle c_gnt_o=1 for that cycle only, slots cleared, next IDLE.
REQ-023 Minimum latency: both requests in cycle N -> CHECK in N+1 -> mem_req_o high in N+2 -> c_gnt_o in the mem_gnt_i cycle (earliest N+2).
REQ-024 Entering RECOVER: error_o pulses for 1 cycle, err_count_o increments by 1, saturating at 0xFFFF.
REQ-025 RECOVER lasts RECOVER_CYCLES cycles: halt_o=1 throughout, recover_o=1 in the final cycle only, slots and timer cleared, then IDLE.
REQ-026 In RECOVER core requests are ignored, c_gnt_o=0, mem_req_o=0.
REQ-027 mem_gnt_i outside ISSUE is ignored.
REQ-028 c_gnt_o never asserted without a same-cycle mem_gnt_i in ISSUE.

Reset
REQ-029 rst_i high at a clock edge -> state IDLE, slots/valids/timer cleared, all outputs 0, err_count_o=0, regardless of current state.
REQ-030 Reset during ISSUE drops mem_req_o the following cycle; no c_gnt_o issued for the aborted pair.

Verification
REQ-031 Both cores write addr 0x4, wdata 0x1, be 0xF same cycle, mem_gnt_i tied 1 -> one mem write 0x4/0x1 two cycles later, c_gnt_o one pulse, error_o never.
REQ-032 core_1 request 3 cycles after core_0, identical read of 0x8 -> single mem read 0x8, no error, err_count_o stays 0.
REQ-033 Writes to 0x4 with wdata 0x1 vs 0x3 -> no mem_req_o, error_o pulse, halt_o 4 cycles, recover_o in 4th, err_count_o=1.
REQ-034 Only core_0 requests, core_1 silent -> RECOVER entered after 8 COLLECT cycles, error_o pulse, err_count_o=1.
REQ-035 Reads differing only in wdata (we=0) -> treated as match, memory read issued.
REQ-036 rst_i asserted while ISSUE waits on mem_gnt_i=0 -> mem_req_o low next cycle, err_count_o=0, next pair processed normally.
